// File: rtl/irda_txd_controller.sv
`default_nettype none
// ============================================================================
// Module   : irda_txd_controller
// Purpose  : IrDA SIR transmitter. Accepts a byte over a valid/ready
//            handshake and sends it as an asynchronous frame on txd
//            (start, DATA_BITS data LSB first, optional parity, stop). It also
//            produces ir_out, a high pulse lasting 3/16 of the bit period at
//            the start of every 0 bit.
// Ports    : clk       - system clock, rising edge
//            reset     - asynchronous, active-low reset
//            tx_data   - byte to send, sampled on acceptance
//            tx_valid  - a byte is offered
//            tx_ready  - block can accept a byte (IDLE only)
//            txd       - UART-level serial output, idles high
//            ir_out    - IrDA pulse output, active high, idles low
//            busy      - a frame is in progress
//            tx_done   - one-cycle pulse in the first IDLE cycle after stop
// Revision : 1.0 - initial release
// ============================================================================
module irda_txd_controller #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 ir_out,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] PULSE_LEN = BAUD_W'(3 * CLKS_PER_BIT / 16);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [2:0]            bit_cnt;
  logic [DATA_BITS-1:0]  shift;
  logic                  parity_bit;
  logic                  accept;
  logic                  baud_wrap;
  logic                  bit_level;

  assign tx_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = tx_valid && tx_ready;
  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and the line level belonging to the current bit
  always_comb begin
    state_next = state;
    bit_level  = 1'b1;
    case (state)
      S_IDLE: begin
        if (accept) state_next = S_START;
      end
      S_START: begin
        bit_level = 1'b0;
        if (baud_wrap) state_next = S_DATA;
      end
      S_DATA: begin
        bit_level = shift[0];
        if (baud_wrap && (bit_cnt == BIT_LAST))
          state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        bit_level = parity_bit;
        if (baud_wrap) state_next = S_STOP;
      end
      S_STOP: begin
        if (baud_wrap) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs. txd/ir_out are registered from the
  // current state, so the line trails the state register by one cycle; this
  // places the start bit one edge after acceptance and lets tx_done coincide
  // with the first IDLE cycle while the stop bit is still on the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift      <= '0;
      parity_bit <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      txd        <= 1'b1;
      ir_out     <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      if (accept) begin
        shift      <= tx_data;
        parity_bit <= (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
        baud_cnt   <= '0;
        bit_cnt    <= '0;
      end else if (busy) begin
        baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
        if ((state == S_DATA) && baud_wrap) begin
          shift   <= shift >> 1;
          bit_cnt <= (bit_cnt == BIT_LAST) ? 3'd0 : bit_cnt + 3'd1;
        end
      end
      txd     <= bit_level;
      ir_out  <= ~bit_level && (baud_cnt < PULSE_LEN);
      tx_done <= (state == S_STOP) && baud_wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irda_txd_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irda_txd_controller
// Purpose  : Self-checking bench for irda_txd_controller. Three instances with
//            different frame formats share the same stimulus; a frame-level
//            reference model predicts every output cycle by cycle from the
//            edge at which each byte was accepted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irda_txd_controller;

  localparam int NI = 3;

  logic       clk;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [NI-1:0] ready, txd, ir, busy, done;

  int checks = 0;
  int errors = 0;
  int e      = 0;   // posedge counter

  // model state per instance
  int         acc_edge  [NI];
  logic [7:0] acc_byte  [NI];
  bit         acc_valid [NI];
  bit         prev_busy [NI];
  logic       exp_txd   [NI];
  logic       exp_ir    [NI];
  logic       exp_done  [NI];
  logic       exp_busy  [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  irda_txd_controller #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_a (
    .clk(clk), .reset(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready[0]), .txd(txd[0]), .ir_out(ir[0]), .busy(busy[0]), .tx_done(done[0]));

  irda_txd_controller #(.CLKS_PER_BIT(32), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_b (
    .clk(clk), .reset(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready[1]), .txd(txd[1]), .ir_out(ir[1]), .busy(busy[1]), .tx_done(done[1]));

  irda_txd_controller #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_c (
    .clk(clk), .reset(rst_n), .tx_data(tx_data[6:0]), .tx_valid(tx_valid),
    .tx_ready(ready[2]), .txd(txd[2]), .ir_out(ir[2]), .busy(busy[2]), .tx_done(done[2]));

  function automatic int cpb(int i);
    return (i == 1) ? 32 : 16;
  endfunction
  function automatic int dbits(int i);
    return (i == 2) ? 7 : 8;
  endfunction
  function automatic int pen(int i);
    return (i == 2) ? 0 : 1;
  endfunction
  function automatic int podd(int i);
    return (i == 1) ? 1 : 0;
  endfunction
  function automatic int flen(int i);
    return cpb(i) * (2 + dbits(i) + pen(i));
  endfunction

  // Level of bit number b within the frame carrying byte_v
  function automatic logic frame_bit(int i, logic [7:0] byte_v, int b);
    logic p;
    if (b == 0) return 1'b0;
    if (b <= dbits(i)) return byte_v[b-1];
    if ((b == dbits(i) + 1) && (pen(i) != 0)) begin
      p = (podd(i) != 0);
      for (int j = 0; j < dbits(i); j++) p = p ^ byte_v[j];
      return p;
    end
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      acc_valid[i] = 1'b0;
      prev_busy[i] = 1'b0;
      exp_txd[i]   = 1'b1;
      exp_ir[i]    = 1'b0;
      exp_done[i]  = 1'b0;
      exp_busy[i]  = 1'b0;
    end
  endtask

  // Expected outputs just after posedge number e
  task automatic model_edge();
    int d;
    for (int i = 0; i < NI; i++) begin
      if (rst_n && !prev_busy[i] && tx_valid) begin
        acc_edge[i]  = e;
        acc_byte[i]  = tx_data;
        acc_valid[i] = 1'b1;
      end
      d = e - acc_edge[i];
      if (acc_valid[i] && d >= 1 && d <= flen(i)) begin
        exp_txd[i] = frame_bit(i, acc_byte[i], (d - 1) / cpb(i));
        exp_ir[i]  = !exp_txd[i] && (((d - 1) % cpb(i)) < (3 * cpb(i) / 16));
      end else begin
        exp_txd[i] = 1'b1;
        exp_ir[i]  = 1'b0;
      end
      exp_done[i]  = acc_valid[i] && (d == flen(i));
      exp_busy[i]  = acc_valid[i] && (d <= flen(i) - 1);
      prev_busy[i] = exp_busy[i];
    end
  endtask

  task automatic compare_all(input string when);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s txd[%0d] e=%0d", when, i, e),      txd[i],   exp_txd[i]);
      check($sformatf("%s ir_out[%0d] e=%0d", when, i, e),   ir[i],    exp_ir[i]);
      check($sformatf("%s tx_done[%0d] e=%0d", when, i, e),  done[i],  exp_done[i]);
      check($sformatf("%s busy[%0d] e=%0d", when, i, e),     busy[i],  exp_busy[i]);
      check($sformatf("%s tx_ready[%0d] e=%0d", when, i, e), ready[i], !exp_busy[i]);
    end
  endtask

  // One clock: drive at negedge, optional async reset check, compare after posedge
  task automatic step(input logic v, input logic [7:0] d, input logic rst_level);
    @(negedge clk);
    tx_valid = v;
    tx_data  = d;
    rst_n    = rst_level;
    if (!rst_level) begin
      model_clear();
      #1;
      compare_all("async_reset");
    end
    @(posedge clk);
    e++;
    model_edge();
    #1;
    compare_all("cycle");
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'($urandom), 1'b1);
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    for (int i = 0; i < NI; i++) acc_edge[i] = 0;
    model_clear();

    repeat (3) step(1'b0, 8'h00, 1'b0);

    // basic frame, then the all-zero byte (odd-parity corner on instance b)
    step(1'b1, 8'hA5, 1'b1);
    idle(400);
    step(1'b1, 8'h00, 1'b1);
    idle(400);

    // busy rejection: offer 0x3C while 0x81 is in flight
    step(1'b1, 8'h81, 1'b1);
    idle(40);
    step(1'b1, 8'h3C, 1'b1);
    idle(400);

    // back-to-back with valid held high
    repeat (100) step(1'b1, 8'h55, 1'b1);
    repeat (500) step(1'b1, 8'hFF, 1'b1);
    idle(400);

    // reset mid-frame (data bit 3 on instance a), then a fresh frame
    step(1'b1, 8'hC3, 1'b1);
    idle(70);
    step(1'b0, 8'hC3, 1'b0);
    step(1'b0, 8'hC3, 1'b0);
    step(1'b1, 8'h12, 1'b1);
    idle(400);

    // random traffic with changing data and occasional resets
    repeat (3000) step(($urandom % 4) == 0, 8'($urandom), ($urandom % 700) != 0);
    idle(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irda_txd_controller.md
# irda_txd_controller

Transmit side of the IrDA SIR link. Accepts a parallel byte through a valid/ready handshake and serialises it as an asynchronous frame on `txd`: one start bit (0), DATA_BITS data bits LSB first, an optional parity bit, and one stop bit (1). It also drives `ir_out`, the IrDA-encoded pulse stream, where each 0 bit is a high pulse lasting 3/16 of the bit period. The frame format and bit timing match what the receive controller expects.

## Interface
- CLKS_PER_BIT, 16, clk cycles per bit period; a multiple of 16 and ≥16
- DATA_BITS, 8, data bits per frame; range 5–8
- PARITY_EN, 1, 1 = append a parity bit after the data bits
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
- clk  input  1  system clock; all logic is on the rising edge
- reset  input  1  asynchronous, active-low reset
- tx_data  input  DATA_BITS  byte to send; sampled only on acceptance
- tx_valid  input  1  a byte is offered on `tx_data`
- tx_ready  output  1  the block can accept a byte (high only in IDLE)
- txd  output  1  UART-level serial output; idles at 1
- ir_out  output  1  IrDA pulse output, active high; idles at 0
- busy  output  1  a frame is in progress (any state except IDLE)
- tx_done  output  1  one-cycle pulse when a frame completes

## Operation
- Accept: a byte is accepted on a rising edge where `tx_valid` and `tx_ready` are both 1.
  - On acceptance, `tx_data` is latched into the shift register, parity is computed from the latched value, the baud counter is cleared, and the state moves to START.
- States and transitions (each bit state lasts exactly CLKS_PER_BIT cycles, timed by a baud counter running 0..CLKS_PER_BIT-1):
  - IDLE: `txd`=1, `tx_ready`=1. Go to START on acceptance.
  - START: `txd`=0. Go to DATA when the baud count wraps.
  - DATA: `txd` = shift[0]. At each baud wrap, shift right and increment the bit counter. After DATA_BITS bits, go to PARITY if PARITY_EN=1, otherwise to STOP.
  - PARITY: `txd` = ^data for even parity, ~^data for odd parity.
  - STOP: `txd`=1. Go to IDLE when the baud count wraps, and assert `tx_done`.
- Parity value: 0xA5 with even parity gives 0; 0x00 with odd parity gives 1.
- IrDA encoding:
  - `ir_out`=1 during baud counts 0..(3·CLKS_PER_BIT/16)-1 of any bit period in which `txd`=0.
  - `ir_out`=0 at all other times, including throughout every 1 bit and throughout IDLE.
- Ignored inputs:
  - `tx_valid` while `busy`=1 has no effect; no queueing.
  - Changes to `tx_data` after acceptance do not affect the frame in progress.
- `txd`, `ir_out` and `tx_done` are registered outputs with no combinational path from the inputs. `tx_ready` and `busy` decode directly from the state register.
- Reset:
  - Asserting `reset` (low) at any time, including mid-frame, forces the following immediately: state=IDLE, `txd`=1, `ir_out`=0, `tx_done`=0, `tx_ready`=1, `busy`=0, counters=0.
  - A partial frame is abandoned, never resumed.

## Timing
- Latency: acceptance at edge N puts `txd`=0 and `ir_out`=1 from edge N+1.
- Frame length: CLKS_PER_BIT·(2+DATA_BITS+PARITY_EN) cycles, i.e. 176 cycles at the defaults.
- Completion: `tx_done` is high for exactly one cycle, the first IDLE cycle after the stop bit; `tx_ready`=1 in that same cycle.
- Back-to-back frames: if `tx_valid`=1 during the `tx_done` cycle, the next start bit begins on the following edge. The minimum frame period is therefore frame length + 1 cycle.
- IrDA pulse width is 3 cycles at CLKS_PER_BIT=16 and 6 cycles at 32.
- Counter widths: the baud counter is $clog2(CLKS_PER_BIT) bits; the bit counter is 3 bits. Neither counter may wrap other than at its terminal value.

## Test plan
- Basic frame (defaults), send 0xA5:
  - `txd` sequence per 16-cycle bit is 0,1,0,1,0,0,1,0,1,0,1, i.e. start, data LSB first, parity 0, stop.
  - `ir_out` gives a 3-cycle pulse at the start of each 0 bit (6 pulses total).
  - `tx_done` pulses at cycle 176 after acceptance.
- Odd parity, no-data corner: PARITY_ODD=1, send 0x00.
  - Result: 8 zero data bits, then parity bit 1, then stop bit 1.
  - `ir_out` shows 9 pulses (start + 8 data).
- Back-to-back: hold `tx_valid`=1 with 0x55 then 0xFF.
  - The second start bit begins exactly 177 cycles after the first acceptance.
  - There is no extra idle bit between frames.
- Busy rejection: pulse `tx_valid` with 0x3C mid-frame while 0x81 is in flight.
  - The 0x81 frame is unchanged.
  - 0x3C is never transmitted.
  - `tx_ready` stays 0 until `tx_done`.
- Reset mid-frame: assert `reset` low during data bit 3.
  - `txd`=1 and `ir_out`=0 immediately, without waiting for a clock edge.
  - `tx_ready`=1.
  - After release, a new byte 0x12 transmits a complete, correct frame.
- No parity: PARITY_EN=0, DATA_BITS=7, send 0x7F.
  - Frame is 9 bits (144 cycles).
  - The stop bit immediately follows data bit 6.
